// File: rtl/execute_pkg.sv
// Shared opcodes, branch condition codes and FSM state for the execute stage.
package execute_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [1:0] BR_EQZ = 2'b00;
    localparam logic [1:0] BR_NEZ = 2'b01;
    localparam logic [1:0] BR_LTZ = 2'b10;
    localparam logic [1:0] BR_GEZ = 2'b11;

    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

    function automatic logic br_taken(input logic [1:0] cond, input logic is_zero,
                                      input logic is_neg);
        case (cond)
            BR_EQZ:  return is_zero;
            BR_NEZ:  return !is_zero;
            BR_LTZ:  return is_neg;
            default: return !is_neg;
        endcase
    endfunction

endpackage

// File: rtl/execute_pipe_if.sv
// Decode-side and memory-side handshake bundle of the execute stage.
interface execute_pipe_if #(parameter int WIDTH = 16);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] data_1;
    logic [WIDTH-1:0] data_2;
    logic [WIDTH-1:0] ext_imm;
    logic [WIDTH-1:0] seq_pc;
    logic             use_imm;
    logic             link;
    logic             br_en;
    logic [1:0]       br_cond;
    logic             jmp;
    logic             br_base;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] data_2_out;
    logic             branch;
    logic [WIDTH-1:0] branch_pc;
    logic             busy;

    modport master (
        output flush, in_valid, op, data_1, data_2, ext_imm, seq_pc, use_imm, link,
               br_en, br_cond, jmp, br_base, out_ready,
        input  in_ready, out_valid, result, data_2_out, branch, branch_pc, busy
    );

    modport slave (
        input  flush, in_valid, op, data_1, data_2, ext_imm, seq_pc, use_imm, link,
               br_en, br_cond, jmp, br_base, out_ready,
        output in_ready, out_valid, result, data_2_out, branch, branch_pc, busy
    );

endinterface

// File: rtl/execute_pipe_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH bits kept.
module mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 2);

    logic             run;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc_nx;

    assign acc_nx = acc + (b_sh[0] ? a_sh : '0);
    assign done   = run & (count == LAST) & !abort;
    // The final step also folds in the top partial product so the whole
    // multiply completes in WIDTH-1 running cycles.
    assign product = acc_nx + (b_sh[1] ? {a_sh[WIDTH-2:0], 1'b0} : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run   <= 1'b0;
            count <= '0;
            acc   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
        end else if (abort) begin
            run   <= 1'b0;
            count <= '0;
            acc   <= '0;
        end else if (start) begin
            run   <= 1'b1;
            count <= '0;
            acc   <= '0;
            a_sh  <= a;
            b_sh  <= b;
        end else if (run) begin
            acc   <= acc_nx;
            a_sh  <= a_sh << 1;
            b_sh  <= b_sh >> 1;
            count <= count + 1'b1;
            if (done) run <= 1'b0;
        end
    end

endmodule

// File: rtl/execute_pipe.sv
// Execute stage: ALU, branch resolution, iterative MUL and a one-entry output register.
module execute_pipe
    import execute_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    execute_pipe_if.slave  bus
);

    state_t           state, state_nx;
    logic             in_ready, busy, xfer, is_mul, mul_start, mul_done;
    logic             load_alu, load_mul;
    logic [WIDTH-1:0] opb, alu_res, tgt, product;
    logic             br_take;

    logic             out_valid, branch_q, pend_br;
    logic [WIDTH-1:0] result_q, data_2_q, pc_q, pend_d2, pend_pc;

    assign opb     = bus.link ? bus.seq_pc : (bus.use_imm ? bus.ext_imm : bus.data_2);
    assign is_mul  = (bus.op == OP_MUL);
    assign br_take = bus.jmp | (bus.br_en & br_taken(bus.br_cond, bus.data_1 == '0,
                                                     bus.data_1[WIDTH-1]));
    assign tgt     = (bus.br_base ? bus.data_1 : bus.seq_pc) + bus.ext_imm;

    always_comb begin
        alu_res = '0;
        case (bus.op)
            OP_ADD:  alu_res = bus.data_1 + opb;
            OP_SUB:  alu_res = opb - bus.data_1;
            OP_AND:  alu_res = bus.data_1 & opb;
            OP_OR:   alu_res = bus.data_1 | opb;
            OP_XOR:  alu_res = bus.data_1 ^ opb;
            OP_SLL:  alu_res = bus.data_1 << opb[SHW-1:0];
            OP_SRL:  alu_res = bus.data_1 >> opb[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .abort   (bus.flush),
        .a       (bus.data_1),
        .b       (opb),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (xfer && is_mul) state_nx = MUL;
                MUL:     if (mul_done)       state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // in_ready never depends on in_valid, only on state, out_ready and flush.
    always_comb begin
        in_ready  = (state == IDLE) & (!out_valid | bus.out_ready) & !bus.flush;
        busy      = (state == MUL);
        xfer      = bus.in_valid & in_ready;
        mul_start = xfer & is_mul;
        load_alu  = xfer & !is_mul;
        load_mul  = (state == MUL) & mul_done;
    end

    // Branch outcome and store data of a MUL are captured at issue, used at completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_br <= 1'b0;
            pend_d2 <= '0;
            pend_pc <= '0;
        end else if (mul_start) begin
            pend_br <= br_take;
            pend_d2 <= bus.data_2;
            pend_pc <= tgt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result_q  <= '0;
            data_2_q  <= '0;
            branch_q  <= 1'b0;
            pc_q      <= '0;
        end else if (bus.flush) begin
            out_valid <= 1'b0;
        end else if (load_alu) begin
            out_valid <= 1'b1;
            result_q  <= alu_res;
            data_2_q  <= bus.data_2;
            branch_q  <= br_take;
            pc_q      <= tgt;
        end else if (load_mul) begin
            out_valid <= 1'b1;
            result_q  <= product;
            data_2_q  <= pend_d2;
            branch_q  <= pend_br;
            pc_q      <= pend_pc;
        end else if (out_valid && bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.busy       = busy;
    assign bus.out_valid  = out_valid;
    assign bus.result     = result_q;
    assign bus.data_2_out = data_2_q;
    assign bus.branch     = branch_q;
    assign bus.branch_pc  = pc_q;

endmodule
